aidc_lite_job_sched: RTL and testbench

Descriptor-queue scheduler that sequences the AIDC-Lite compression engine. Software or a config block pushes compression jobs (source address, destination address, length in 128 B blocks) into a small FIFO. The scheduler launches them one at a time on the engine's start/done handshake, holds the job parameters stable for the whole job, and reports completions through a counter and a sticky interrupt. It sits between the register/config layer and the compression engine.

---
 rtl/aidc_lite_job_sched.sv | 160 ++++++++++++++++
 tb/tb_aidc_lite_job_sched.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aidc_lite_job_sched.sv
// Descriptor FIFO plus a launch FSM that feeds the AIDC-Lite compression engine
// one job at a time and counts/flags completions.
module aidc_lite_job_sched #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      push_i,
    input  logic [31:0]               push_src_i,
    input  logic [31:0]               push_dst_i,
    input  logic [24:0]               push_len_i,
    output logic                      push_err_o,
    output logic                      full_o,
    output logic [$clog2(DEPTH):0]    count_o,
    input  logic                      en_i,
    output logic                      busy_o,
    output logic [31:0]               eng_src_o,
    output logic [31:0]               eng_dst_o,
    output logic [24:0]               eng_len_o,
    output logic                      eng_start_o,
    input  logic                      eng_done_i,
    input  logic                      irq_en_i,
    input  logic                      irq_clr_i,
    output logic                      irq_o,
    output logic [CNT_W-1:0]          done_cnt_o
);
    localparam int AW = $clog2(DEPTH);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_ARM   = 2'd2;
    localparam logic [1:0] S_WAIT  = 2'd3;

    logic [31:0] src_mem [DEPTH];
    logic [31:0] dst_mem [DEPTH];
    logic [24:0] len_mem [DEPTH];

    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic [1:0]       state_q, state_d;
    logic [31:0]      src_q, src_d;
    logic [31:0]      dst_q, dst_d;
    logic [24:0]      len_q, len_d;
    logic             start_q, start_d;
    logic             push_err_q, push_err_d;
    logic             irq_q, irq_d;
    logic [CNT_W-1:0] done_cnt_q, done_cnt_d;

    logic full;
    logic push_ok;
    logic launch;
    logic complete;

    // Full is judged on pre-edge occupancy, so a pop on the same edge cannot rescue a push.
    assign full     = (count_q == (AW + 1)'(DEPTH));
    assign push_ok  = push_i && !full && (push_len_i != '0);
    assign launch   = (state_q == S_IDLE) && (count_q != '0) && en_i;
    assign complete = (state_q == S_WAIT) && eng_done_i;

    // Storage is not reset: only entries between the pointers are ever read.
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
        always_ff @(posedge clk) begin
            if (push_ok && (wr_ptr_q == AW'(gi))) begin
                src_mem[gi] <= push_src_i;
                dst_mem[gi] <= push_dst_i;
                len_mem[gi] <= push_len_i;
            end
        end
    end

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        state_d    = state_q;
        src_d      = src_q;
        dst_d      = dst_q;
        len_d      = len_q;
        start_d    = 1'b0;
        push_err_d = push_i && !push_ok;
        irq_d      = irq_q;
        done_cnt_d = done_cnt_q;

        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (launch) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
            src_d    = src_mem[rd_ptr_q];
            dst_d    = dst_mem[rd_ptr_q];
            len_d    = len_mem[rd_ptr_q];
            start_d  = 1'b1;
        end
        case ({push_ok, launch})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        // The engine's done level is still high from the previous job during S_ARM.
        case (state_q)
            S_IDLE:  if (launch) state_d = S_START;
            S_START: state_d = S_ARM;
            S_ARM:   state_d = S_WAIT;
            S_WAIT:  if (eng_done_i) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        if (complete) begin
            done_cnt_d = done_cnt_q + 1'b1;
        end
        if (complete && irq_en_i) begin
            irq_d = 1'b1;
        end else if (irq_clr_i) begin
            irq_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            state_q    <= S_IDLE;
            src_q      <= '0;
            dst_q      <= '0;
            len_q      <= '0;
            start_q    <= 1'b0;
            push_err_q <= 1'b0;
            irq_q      <= 1'b0;
            done_cnt_q <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            state_q    <= state_d;
            src_q      <= src_d;
            dst_q      <= dst_d;
            len_q      <= len_d;
            start_q    <= start_d;
            push_err_q <= push_err_d;
            irq_q      <= irq_d;
            done_cnt_q <= done_cnt_d;
        end
    end

    assign push_err_o  = push_err_q;
    assign full_o      = full;
    assign count_o     = count_q;
    assign busy_o      = (state_q != S_IDLE);
    assign eng_src_o   = src_q;
    assign eng_dst_o   = dst_q;
    assign eng_len_o   = len_q;
    assign eng_start_o = start_q;
    assign irq_o       = irq_q;
    assign done_cnt_o  = done_cnt_q;

endmodule

// File: tb/tb_aidc_lite_job_sched.sv
// Bench for aidc_lite_job_sched: vector table, directed corner sequences and a
// randomized run checked against a queue-based job model.
module tb_aidc_lite_job_sched;
    logic        clk;
    logic        rst_n;
    logic        push_i;
    logic [31:0] push_src_i;
    logic [31:0] push_dst_i;
    logic [24:0] push_len_i;
    logic        push_err_o;
    logic        full_o;
    logic [2:0]  count_o;
    logic        en_i;
    logic        busy_o;
    logic [31:0] eng_src_o;
    logic [31:0] eng_dst_o;
    logic [24:0] eng_len_o;
    logic        eng_start_o;
    logic        eng_done_i;
    logic        irq_en_i;
    logic        irq_clr_i;
    logic        irq_o;
    logic [15:0] done_cnt_o;

    aidc_lite_job_sched #(.DEPTH(4), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .push_i(push_i), .push_src_i(push_src_i), .push_dst_i(push_dst_i),
        .push_len_i(push_len_i), .push_err_o(push_err_o), .full_o(full_o),
        .count_o(count_o), .en_i(en_i), .busy_o(busy_o),
        .eng_src_o(eng_src_o), .eng_dst_o(eng_dst_o), .eng_len_o(eng_len_o),
        .eng_start_o(eng_start_o), .eng_done_i(eng_done_i),
        .irq_en_i(irq_en_i), .irq_clr_i(irq_clr_i), .irq_o(irq_o),
        .done_cnt_o(done_cnt_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- reference model: a job queue plus the age of the job in flight
    typedef struct packed {
        logic [31:0] src;
        logic [31:0] dst;
        logic [24:0] len;
    } desc_t;

    desc_t       mq[$];
    int          m_age;     // -1 idle, 0 start cycle, 1 arm cycle, >=2 waiting on engine
    logic [31:0] m_src, m_dst;
    logic [24:0] m_len;
    logic [15:0] m_cnt;
    logic        m_irq, m_err, m_start;

    task automatic model_reset();
        mq.delete();
        m_age = -1;
        m_src = '0; m_dst = '0; m_len = '0;
        m_cnt = '0; m_irq = 1'b0; m_err = 1'b0; m_start = 1'b0;
    endtask

    task automatic model_step();
        bit    acc, launch, fin;
        desc_t d;
        acc    = push_i && (mq.size() < 4) && (push_len_i != 0);
        launch = (m_age < 0) && (mq.size() != 0) && en_i;
        fin    = (m_age >= 2) && eng_done_i;
        m_err  = push_i && !acc;
        m_start = 1'b0;
        if (fin) begin
            m_age = -1;
            m_cnt = m_cnt + 16'd1;
        end else if (m_age >= 0) begin
            m_age++;
        end
        if (fin && irq_en_i) m_irq = 1'b1;
        else if (irq_clr_i)  m_irq = 1'b0;
        if (launch) begin
            d = mq.pop_front();
            m_src = d.src; m_dst = d.dst; m_len = d.len;
            m_age = 0;
            m_start = 1'b1;
        end
        if (acc) begin
            d.src = push_src_i; d.dst = push_dst_i; d.len = push_len_i;
            mq.push_back(d);
        end
    endtask

    task automatic model_cmp(input string tag);
        chk({tag, ".count"}, 32'(count_o), mq.size());
        chk({tag, ".full"}, 32'(full_o), 32'(mq.size() == 4));
        chk({tag, ".err"}, 32'(push_err_o), 32'(m_err));
        chk({tag, ".busy"}, 32'(busy_o), 32'(m_age >= 0));
        chk({tag, ".start"}, 32'(eng_start_o), 32'(m_start));
        chk({tag, ".src"}, eng_src_o, m_src);
        chk({tag, ".dst"}, eng_dst_o, m_dst);
        chk({tag, ".len"}, 32'(eng_len_o), 32'(m_len));
        chk({tag, ".done_cnt"}, 32'(done_cnt_o), 32'(m_cnt));
        chk({tag, ".irq"}, 32'(irq_o), 32'(m_irq));
    endtask

    // Engine stand-in: done drops for eng lat cycles after each observed start.
    int eng_rem = 0;
    int eng_lat_fixed = 3;
    bit eng_rand = 1'b0;
    int n_starts = 0;

    task automatic cycle(input string tag);
        model_step();
        tick();
        model_cmp(tag);
        if (eng_start_o) begin
            n_starts++;
            eng_rem = eng_rand ? int'($urandom_range(0, 6)) : eng_lat_fixed;
        end
        eng_done_i = (eng_rem == 0);
        if (eng_rem > 0) eng_rem--;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, ".count"}, 32'(count_o), 0);
        chk({tag, ".full"}, 32'(full_o), 0);
        chk({tag, ".busy"}, 32'(busy_o), 0);
        chk({tag, ".start"}, 32'(eng_start_o), 0);
        chk({tag, ".err"}, 32'(push_err_o), 0);
        chk({tag, ".irq"}, 32'(irq_o), 0);
        chk({tag, ".done_cnt"}, 32'(done_cnt_o), 0);
        chk({tag, ".eng"}, eng_src_o | eng_dst_o | 32'(eng_len_o), 0);
    endtask

    // Called one time unit after an edge; reset is asserted and released between edges.
    task automatic do_async_reset(input string tag);
        #2 rst_n = 1'b0;
        #1 chk_reset_vals(tag);
        model_reset();
        eng_rem = 0;
        eng_done_i = 1'b1;
        @(posedge clk);
        #3 rst_n = 1'b1;
    endtask

    task automatic job_min(input logic [31:0] s, input logic [31:0] d,
                           input logic [24:0] l, input logic clr);
        push_i = 1'b1; push_src_i = s; push_dst_i = d; push_len_i = l;
        tick();
        push_i = 1'b0;
        tick();
        tick();
        tick();
        irq_clr_i = clr;
        tick();
        irq_clr_i = 1'b0;
    endtask

    typedef struct {
        logic        push;
        logic [24:0] len;
        logic        en;
        logic [2:0]  exp_count;
        logic        exp_full;
        logic        exp_err;
        logic        exp_busy;
        logic        exp_start;
        logic [24:0] exp_len;
    } vec_t;

    vec_t vecs[14];

    initial begin
        // push len en  cnt full err busy start elen
        vecs[0]  = '{1'b1, 25'd0, 1'b0, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0, 25'd0};
        vecs[1]  = '{1'b0, 25'd0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 25'd0};
        vecs[2]  = '{1'b1, 25'd3, 1'b0, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0, 25'd0};
        vecs[3]  = '{1'b1, 25'd4, 1'b0, 3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 25'd0};
        vecs[4]  = '{1'b1, 25'd5, 1'b0, 3'd3, 1'b0, 1'b0, 1'b0, 1'b0, 25'd0};
        vecs[5]  = '{1'b1, 25'd6, 1'b0, 3'd4, 1'b1, 1'b0, 1'b0, 1'b0, 25'd0};
        vecs[6]  = '{1'b1, 25'd7, 1'b0, 3'd4, 1'b1, 1'b1, 1'b0, 1'b0, 25'd0};
        vecs[7]  = '{1'b0, 25'd0, 1'b0, 3'd4, 1'b1, 1'b0, 1'b0, 1'b0, 25'd0};
        vecs[8]  = '{1'b0, 25'd0, 1'b1, 3'd3, 1'b0, 1'b0, 1'b1, 1'b1, 25'd3};
        vecs[9]  = '{1'b0, 25'd0, 1'b1, 3'd3, 1'b0, 1'b0, 1'b1, 1'b0, 25'd3};
        vecs[10] = '{1'b0, 25'd0, 1'b1, 3'd3, 1'b0, 1'b0, 1'b1, 1'b0, 25'd3};
        vecs[11] = '{1'b0, 25'd0, 1'b0, 3'd3, 1'b0, 1'b0, 1'b0, 1'b0, 25'd3};
        vecs[12] = '{1'b0, 25'd0, 1'b0, 3'd3, 1'b0, 1'b0, 1'b0, 1'b0, 25'd3};
        vecs[13] = '{1'b0, 25'd0, 1'b1, 3'd2, 1'b0, 1'b0, 1'b1, 1'b1, 25'd4};

        rst_n = 1'b0;
        push_i = 1'b0; push_src_i = '0; push_dst_i = '0; push_len_i = '0;
        en_i = 1'b0; eng_done_i = 1'b1; irq_en_i = 1'b0; irq_clr_i = 1'b0;
        model_reset();
        @(posedge clk);
        #1 chk_reset_vals("por");
        @(posedge clk);
        #3 rst_n = 1'b1;

        // Vector table: zero length, fill/overflow with en low, then a launch
        // with done held high (ignored in the arm cycle) and en dropping mid-job.
        for (int i = 0; i < 14; i++) begin
            push_i = vecs[i].push;
            push_len_i = vecs[i].len;
            push_src_i = 32'(vecs[i].len) << 8;
            push_dst_i = 32'(vecs[i].len) << 12;
            en_i = vecs[i].en;
            tick();
            chk($sformatf("vec%0d.count", i), 32'(count_o), 32'(vecs[i].exp_count));
            chk($sformatf("vec%0d.full", i), 32'(full_o), 32'(vecs[i].exp_full));
            chk($sformatf("vec%0d.err", i), 32'(push_err_o), 32'(vecs[i].exp_err));
            chk($sformatf("vec%0d.busy", i), 32'(busy_o), 32'(vecs[i].exp_busy));
            chk($sformatf("vec%0d.start", i), 32'(eng_start_o), 32'(vecs[i].exp_start));
            chk($sformatf("vec%0d.len", i), 32'(eng_len_o), 32'(vecs[i].exp_len));
        end
        push_i = 1'b0;
        en_i = 1'b0;

        // Single job: start 2 cycles after push, engine busy for 10 cycles.
        do_async_reset("rst_a");
        en_i = 1'b1;
        push_i = 1'b1; push_src_i = 32'h1000; push_dst_i = 32'h8000; push_len_i = 25'd2;
        tick();
        push_i = 1'b0;
        chk("single.count_e0", 32'(count_o), 1);
        chk("single.start_e0", 32'(eng_start_o), 0);
        tick();
        chk("single.start", 32'(eng_start_o), 1);
        chk("single.src", eng_src_o, 32'h1000);
        chk("single.dst", eng_dst_o, 32'h8000);
        chk("single.len", 32'(eng_len_o), 2);
        chk("single.busy", 32'(busy_o), 1);
        eng_done_i = 1'b0;
        begin
            int extra_starts = 0;
            int idle_seen = 0;
            for (int i = 0; i < 10; i++) begin
                tick();
                if (eng_start_o) extra_starts++;
                if (!busy_o) idle_seen++;
            end
            chk("single.extra_starts", extra_starts, 0);
            chk("single.busy_hold", idle_seen, 0);
        end
        eng_done_i = 1'b1;
        tick();
        chk("single.done_cnt", 32'(done_cnt_o), 1);
        chk("single.busy_fall", 32'(busy_o), 0);
        chk("single.src_hold", eng_src_o, 32'h1000);

        // Interrupt: set beats a simultaneous clear; clear alone drops it; disabled stays low.
        irq_en_i = 1'b1;
        job_min(32'h2000, 32'h9000, 25'd1, 1'b1);
        chk("irq.set_wins", 32'(irq_o), 1);
        chk("irq.done_cnt", 32'(done_cnt_o), 2);
        irq_clr_i = 1'b1;
        tick();
        irq_clr_i = 1'b0;
        chk("irq.cleared", 32'(irq_o), 0);
        irq_en_i = 1'b0;
        job_min(32'h3000, 32'hA000, 25'd5, 1'b0);
        chk("irq.disabled", 32'(irq_o), 0);
        chk("irq.done_cnt2", 32'(done_cnt_o), 3);

        // Async reset while waiting on the engine with 2 entries still queued.
        do_async_reset("rst_b");
        en_i = 1'b1;
        eng_rand = 1'b0;
        eng_lat_fixed = 8;
        for (int i = 0; i < 3; i++) begin
            push_i = 1'b1;
            push_src_i = 32'h100 * (i + 1); push_dst_i = 32'h4000 + i; push_len_i = 25'(i + 1);
            cycle("preq");
        end
        push_i = 1'b0;
        for (int i = 0; i < 3; i++) cycle("preq_wait");
        chk("midwait.queued", 32'(count_o), 2);
        chk("midwait.busy", 32'(busy_o), 1);
        do_async_reset("rst_mid");
        n_starts = 0;
        for (int i = 0; i < 6; i++) cycle("post_rst");
        chk("post_rst.no_start", n_starts, 0);

        // Back-to-back drain of 3 queued jobs with a fixed-latency engine.
        en_i = 1'b0;
        eng_lat_fixed = 3;
        for (int i = 0; i < 3; i++) begin
            push_i = 1'b1;
            push_src_i = 32'hC000 + 32'h10 * i; push_dst_i = 32'hD000 + i; push_len_i = 25'(10 + i);
            cycle("drain_fill");
        end
        push_i = 1'b0;
        en_i = 1'b1;
        n_starts = 0;
        for (int i = 0; i < 30; i++) cycle("drain");
        chk("drain.starts", n_starts, 3);
        chk("drain.done_cnt", 32'(done_cnt_o), 3);
        chk("drain.last_src", eng_src_o, 32'hC020);

        // Randomized traffic against the model, with one async reset midway.
        eng_rand = 1'b1;
        for (int i = 0; i < 600; i++) begin
            push_i     = ($urandom_range(0, 2) == 0);
            push_src_i = $urandom();
            push_dst_i = $urandom();
            push_len_i = ($urandom_range(0, 7) == 0) ? 25'd0 : 25'($urandom_range(1, 5000));
            en_i       = ($urandom_range(0, 9) != 0);
            irq_en_i   = 1'($urandom_range(0, 1));
            irq_clr_i  = ($urandom_range(0, 5) == 0);
            if (i == 300) begin
                do_async_reset("rst_rand");
            end else begin
                cycle("rand");
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
